// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// data stage. Data requests win unless the fetch side has been passed over
// STARVE_LIMIT times in a row; a BUSY state that sees no ramAck within
// TIMEOUT cycles is aborted with a poison word and a sticky error flag.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic [31:0] ifRdata,
  output logic        ifReady,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] memAddr,
  input  logic [31:0] memWdata,
  output logic [31:0] memRdata,
  output logic        memReady,
  output logic        ramReq,
  output logic        ramWe,
  output logic [31:0] ramAddr,
  output logic [31:0] ramWdata,
  input  logic [31:0] ramRdata,
  input  logic        ramAck,
  output logic        stallIF,
  output logic        stallPipe,
  output logic        err
);

  localparam int unsigned SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [31:0]   ABORT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    MEM_BUSY,
    DONE
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          data_req;

  assign data_req  = memRead | memWrite;
  assign stallIF   = ifReq & ~ifReady;
  assign stallPipe = data_req & ~memReady;

  // Arbitration FSM; every memory-side and completion output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      ramReq     <= 1'b0;
      ramWe      <= 1'b0;
      ramAddr    <= '0;
      ramWdata   <= '0;
      ifRdata    <= '0;
      memRdata   <= '0;
      ifReady    <= 1'b0;
      memReady   <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (data_req && ((starve_cnt < STARVE_MAX) || !ifReq)) begin
            state    <= MEM_BUSY;
            ramReq   <= 1'b1;
            ramWe    <= memWrite;
            ramAddr  <= memAddr;
            ramWdata <= memWdata;
            // With ifReq high this branch implies starve_cnt < STARVE_MAX,
            // so the increment can never pass the saturation value.
            starve_cnt <= ifReq ? starve_cnt + 1'b1 : '0;
          end else if (ifReq) begin
            state      <= IF_BUSY;
            ramReq     <= 1'b1;
            ramWe      <= 1'b0;
            ramAddr    <= ifAddr;
            ramWdata   <= '0;
            starve_cnt <= '0;
          end
        end
        IF_BUSY, MEM_BUSY: begin
          // tmo_cnt holds the number of ack-less cycles already spent, so the
          // TIMEOUT-th ack-less cycle is the one where it equals TIMEOUT-1.
          if (ramAck || (tmo_cnt == TMO_LAST)) begin
            state  <= DONE;
            ramReq <= 1'b0;
            ramWe  <= 1'b0;
            if (state == IF_BUSY) begin
              ifRdata <= ramAck ? ramRdata : ABORT_DATA;
              ifReady <= 1'b1;
            end else begin
              memRdata <= ramAck ? ramRdata : ABORT_DATA;
              memReady <= 1'b1;
            end
            if (!ramAck) begin
              err <= 1'b1;
            end
          end
          if (!ramAck) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          ifReady  <= 1'b0;
          memReady <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
